// File: rtl/pipeline_valid_ready_pkg.sv
// rtl/pipeline_valid_ready_pkg.sv - shared constants and helpers for the elastic pipeline
package pipeline_valid_ready_pkg;

    // Widest valid vector the occupancy helper accepts.
    localparam int unsigned MAX_DEPTH = 64;

    function automatic int unsigned count_ones(input logic [MAX_DEPTH-1:0] bits);
        int unsigned n;
        n = 0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            n = n + 32'(bits[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pipeline_valid_ready_stage.sv
// rtl/pipeline_valid_ready_stage.sv - one data register plus valid bit with load, flush and async reset
module pipeline_valid_ready_stage #(
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Flush clears only the valid bit; the data register changes solely on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= RESET_VALUE;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipeline_valid_ready.sv
// rtl/pipeline_valid_ready.sv - elastic DEPTH-stage valid/ready register pipeline with flush and occupancy count
module pipeline_valid_ready
    import pipeline_valid_ready_pkg::*;
#(
    parameter int                WIDTH       = 1,
    parameter int                DEPTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    localparam int               CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH:0]           w_ready;
    logic [DEPTH-1:0]         w_load;
    logic [DEPTH-1:0]         w_v;
    logic [DEPTH-1:0]         w_v_in;
    logic [DEPTH-1:0]         w_v_next;
    logic [MAX_DEPTH-1:0]     w_v_wide;
    logic [WIDTH-1:0]         w_d    [DEPTH];
    logic [WIDTH-1:0]         w_d_in [DEPTH];
    logic [CW-1:0]            r_count;

    // A stage may load when it is empty or everything ahead of it moves.
    always_comb begin
        w_ready        = '0;
        w_ready[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_ready[k] = !w_v[k] || w_ready[k+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_d_in[i] = in_data;
            assign w_v_in[i] = in_valid;
        end else begin : g_body
            assign w_d_in[i] = w_d[i-1];
            assign w_v_in[i] = w_v[i-1];
        end

        assign w_load[i]   = w_ready[i] && !flush;
        assign w_v_next[i] = flush ? 1'b0 : (w_load[i] ? w_v_in[i] : w_v[i]);

        pipeline_valid_ready_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_flush (flush),
            .i_load  (w_load[i]),
            .i_data  (w_d_in[i]),
            .i_valid (w_v_in[i]),
            .o_data  (w_d[i]),
            .o_valid (w_v[i])
        );
    end

    assign w_v_wide = MAX_DEPTH'(w_v_next);

    // Count tracks the valid bits as they will be after this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= CW'(count_ones(w_v_wide));
        end
    end

    assign in_ready  = w_ready[0] && !flush;
    assign out_valid = w_v[DEPTH-1] && !flush;
    assign out_data  = w_d[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_pipeline_valid_ready.sv
// tb/tb_pipeline_valid_ready.sv - self-checking bench for pipeline_valid_ready against a positional queue model
module tb_pipeline_valid_ready;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    pipeline_valid_ready #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         pos;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    n_in   = 0;
    int    n_out  = 0;
    logic  g_ix   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; drives inputs, checks mid-cycle, then advances the model over the next edge.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl, input string tag);
        logic e_ir, e_ov, ix, ox;
        int   lim, np;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #2;
        e_ir = !fl && ((q.size() < DEPTH) || ordy);
        e_ov = 1'b0;
        if (!fl && q.size() > 0) e_ov = (q[0].pos == DEPTH - 1);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        if (e_ov) chk({tag, ".out_data"}, 32'(out_data), 32'(q[0].data));
        ix = iv && e_ir;
        ox = e_ov && ordy;
        g_ix = ix;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (ox) begin
                void'(q.pop_front());
                n_out++;
            end
            lim = DEPTH - 1;
            for (int k = 0; k < q.size(); k++) begin
                np = (q[k].pos + 1 <= lim) ? q[k].pos + 1 : q[k].pos;
                q[k].pos = np;
                lim = np - 1;
            end
            if (ix) begin
                q.push_back('{data: id, pos: 0});
                n_in++;
            end
        end
    endtask

    initial begin
        int         in0, out0;
        logic       iv, ordy, fl;
        logic [7:0] pend;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.out_data", 32'(out_data), 32'(RV));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int v = 1; v <= 5; v++) cycle(1'b1, 8'(v), 1'b1, 1'b0, "stream");
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "stream_drain");

        for (int v = 8'h10; v <= 8'h13; v++) cycle(1'b1, 8'(v), 1'b0, 1'b0, "bp_fill");
        chk("bp.count_full", 32'(count), 32'd3);
        chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        cycle(1'b1, 8'h13, 1'b1, 1'b0, "bp_release");
        for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "bp_drain");
        chk("bp.total_in", 32'(n_in), 32'd9);
        chk("bp.total_out", 32'(n_out), 32'd9);

        cycle(1'b1, 8'h20, 1'b0, 1'b0, "bub");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, "bub");
        cycle(1'b1, 8'h21, 1'b0, 1'b0, "bub");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, "bub_stall");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, "bub_stall");
        chk("bub.count", 32'(count), 32'd2);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "bub_drain");

        cycle(1'b1, 8'h30, 1'b0, 1'b0, "fl_fill");
        cycle(1'b1, 8'h31, 1'b0, 1'b0, "fl_fill");
        cycle(1'b1, 8'h32, 1'b1, 1'b1, "fl_flush");
        chk("fl.count_after", 32'(count), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "fl_after");

        for (int v = 8'h40; v <= 8'h42; v++) cycle(1'b1, 8'(v), 1'b0, 1'b0, "full_fill");
        in0 = n_in; out0 = n_out;
        for (int k = 0; k < 10; k++) cycle(1'b1, 8'(8'h50 + k), 1'b1, 1'b0, "full_run");
        chk("full.accepts", 32'(n_in - in0), 32'd10);
        chk("full.emits", 32'(n_out - out0), 32'd10);
        chk("full.count", 32'(count), 32'd3);

        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid.count", 32'(count), 32'd0);
        chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid.out_data", 32'(out_data), 32'(RV));
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        iv = 1'b0; pend = 8'h00;
        g_ix = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!(iv && !g_ix)) begin
                iv   = ($urandom_range(0, 3) != 0);
                pend = 8'($urandom);
            end
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            cycle(iv, pend, ordy, fl, "rand");
            if (fl) iv = 1'b0;
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "rand_drain");
        chk("final.count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
